// File: rtl/spi_shift_ctrl.sv
// SPI shift engine: serialises tx_data onto mosi and collects miso into rx_data,
// paced by the clock generator's edge strobes. Define SPI_SHIFT_CTRL_IRQ_EN for irq/irq_ack.
module spi_shift_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              lsb,
    input  logic              tx_negedge,
    input  logic              rx_negedge,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              miso,
    output logic              go,
    output logic              tip,
    output logic              last_clk,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              done
`ifdef SPI_SHIFT_CTRL_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_ack
`endif
);
    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [DATA_W-1:0] r_rx, w_rx_next;
    logic [CNT_W-1:0]  r_len, w_len_next;
    logic [CNT_W-1:0]  r_tx_cnt, w_tx_cnt_next;
    logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_next;
    logic              r_lsb, w_lsb_next;
    logic              r_tx_neg, w_tx_neg_next;
    logic              r_rx_neg, w_rx_neg_next;
    logic              r_go, w_go_next;
    logic              r_tip, w_tip_next;
    logic              r_last_clk, w_last_clk_next;
    logic              r_mosi, w_mosi_next;
    logic              r_done, w_done_next;

    logic [CNT_W-1:0]  w_len_eff;
    logic [IDX_W-1:0]  w_tx_idx;
    logic [IDX_W-1:0]  w_rx_idx;
    logic              w_tx_edge;
    logic              w_rx_edge;

    assign w_len_eff = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;
    assign w_tx_edge = r_tx_neg ? neg_edge : pos_edge;
    assign w_rx_edge = r_rx_neg ? neg_edge : pos_edge;
    // Counters run N..1, so the bit position follows directly from the remaining count.
    assign w_tx_idx  = IDX_W'(r_lsb ? (r_len - r_tx_cnt) : (r_tx_cnt - CNT_W'(1)));
    assign w_rx_idx  = IDX_W'(r_len - r_rx_cnt);

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_rx_next     = r_rx;
        w_len_next    = r_len;
        w_tx_cnt_next = r_tx_cnt;
        w_rx_cnt_next = r_rx_cnt;
        w_lsb_next    = r_lsb;
        w_tx_neg_next = r_tx_neg;
        w_rx_neg_next = r_rx_neg;
        w_go_next     = 1'b0;
        w_tip_next    = r_tip;
        w_mosi_next   = r_mosi;
        w_done_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next  = ST_RUN;
                    w_shift_next  = tx_data;
                    w_rx_next     = '0;
                    w_len_next    = w_len_eff;
                    w_tx_cnt_next = w_len_eff;
                    w_rx_cnt_next = w_len_eff;
                    w_lsb_next    = lsb;
                    w_tx_neg_next = tx_negedge;
                    w_rx_neg_next = rx_negedge;
                    w_go_next     = 1'b1;
                    w_tip_next    = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_tx_edge && r_tx_cnt != '0) begin
                    w_mosi_next   = r_shift[w_tx_idx];
                    w_tx_cnt_next = r_tx_cnt - CNT_W'(1);
                end
                if (w_rx_edge && r_rx_cnt != '0) begin
                    if (r_lsb)
                        w_rx_next[w_rx_idx] = miso;
                    else
                        w_rx_next = {r_rx[DATA_W-2:0], miso};
                    w_rx_cnt_next = r_rx_cnt - CNT_W'(1);
                    if (r_rx_cnt == CNT_W'(1)) begin
                        w_state_next = ST_IDLE;
                        w_tip_next   = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Built from next values so last_clk is valid the cycle right after the final launch.
        w_last_clk_next = w_tip_next && (w_tx_cnt_next == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_rx       <= '0;
            r_len      <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_lsb      <= 1'b0;
            r_tx_neg   <= 1'b0;
            r_rx_neg   <= 1'b0;
            r_go       <= 1'b0;
            r_tip      <= 1'b0;
            r_last_clk <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_rx       <= w_rx_next;
            r_len      <= w_len_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_lsb      <= w_lsb_next;
            r_tx_neg   <= w_tx_neg_next;
            r_rx_neg   <= w_rx_neg_next;
            r_go       <= w_go_next;
            r_tip      <= w_tip_next;
            r_last_clk <= w_last_clk_next;
            r_mosi     <= w_mosi_next;
            r_done     <= w_done_next;
        end
    end

    assign go       = r_go;
    assign tip      = r_tip;
    assign last_clk = r_last_clk;
    assign mosi     = r_mosi;
    assign rx_data  = r_rx;
    assign done     = r_done;

`ifdef SPI_SHIFT_CTRL_IRQ_EN
    logic r_irq;

    // A done pulse wins over a coincident acknowledge so no completion is lost.
    always_ff @(posedge clk_in) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else if (r_done)
            r_irq <= 1'b1;
        else if (irq_ack)
            r_irq <= 1'b0;
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Self-checking bench for spi_shift_ctrl: a behavioural clock-generator stand-in
// drives edge strobes; expected bit streams and received words come from the transfer rules.
module tb_spi_shift_ctrl;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              lsb;
    logic              tx_negedge;
    logic              rx_negedge;
    logic [DATA_W-1:0] tx_data;
    logic              pos_edge;
    logic              neg_edge;
    logic              miso;
    logic              miso_drv;
    logic              loop_en;
    logic              go;
    logic              tip;
    logic              last_clk;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              done;
`ifdef SPI_SHIFT_CTRL_IRQ_EN
    logic              irq;
    logic              irq_ack;
`endif

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : miso_drv;

    spi_shift_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_in     (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .lsb        (lsb),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .tx_data    (tx_data),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .miso       (miso),
        .go         (go),
        .tip        (tip),
        .last_clk   (last_clk),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .done       (done)
`ifdef SPI_SHIFT_CTRL_IRQ_EN
        ,
        .irq        (irq),
        .irq_ack    (irq_ack)
`endif
    );

    int                n_checks = 0;
    int                n_pass   = 0;
    logic              obs_mosi[$];
    logic              rx_bits[$];
    int                obs_tx_used;
    int                obs_proto_err;
    int                obs_mosi_err;
    int                obs_timeout;
    int                exp_n;
    logic [DATA_W-1:0] obs_rx;
    logic [DATA_W-1:0] exp_rx;

    // mode: 0 = random miso, 1 = miso looped to mosi, 2 = miso tied high.
    // Returns on the negedge where done is observed (or early on abort/timeout).
    task automatic run_xfer(input logic [CNT_W-1:0] l, input logic lsb_i, input logic txn,
                            input logic rxn, input logic [DATA_W-1:0] d, input int div,
                            input int mode, input int abort_after, input bit poke,
                            input bit skip_start);
        int tx_given = 0;
        int rx_given = 0;
        int gcnt     = 0;
        int cyc      = 0;
        bit prev_tx = 0, prev_final = 0, poked = 0;
        bit phase, tx_str, rx_str, b, eb;
        exp_n = (l == '0 || int'(l) > DATA_W) ? DATA_W : int'(l);
        obs_mosi.delete();
        rx_bits.delete();
        obs_tx_used = 0; obs_proto_err = 0; obs_mosi_err = 0; obs_timeout = 0;
        obs_rx = '0;
        loop_en  = (mode == 1);
        miso_drv = (mode == 2);
        if (!skip_start) begin
            len = l; lsb = lsb_i; tx_negedge = txn; rx_negedge = rxn; tx_data = d;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (go !== 1'b1 || tip !== 1'b1) obs_proto_err++;
        phase = txn;
        forever begin
            if (prev_tx) obs_mosi.push_back(mosi);
            if (cyc > 0 && go !== 1'b0) obs_proto_err++;
            if (last_clk !== (!prev_final && tx_given >= exp_n)) obs_proto_err++;
            if (done !== prev_final) obs_proto_err++;
            if (prev_final) begin
                if (tip !== 1'b0) obs_proto_err++;
                obs_rx = rx_data;
                break;
            end
            if (abort_after > 0 && tx_given >= abort_after) break;
            if (cyc >= 4000) begin obs_timeout = 1; break; end
            pos_edge = 1'b0; neg_edge = 1'b0; tx_str = 0; rx_str = 0; prev_tx = 0;
            start = 1'b0;
            if (poke && !poked && tx_given == 2) begin
                start = 1'b1; len = 6'($urandom_range(1, 63)); tx_data = $urandom; lsb = ~lsb_i;
                poked = 1;
            end
            if (mode == 0) miso_drv = 1'($urandom_range(0, 1));
            if (gcnt == div) begin
                gcnt = 0;
                if (div == 0) begin
                    pos_edge = 1'b1; neg_edge = 1'b1; tx_str = 1; rx_str = 1;
                end else begin
                    if (phase) neg_edge = 1'b1; else pos_edge = 1'b1;
                    tx_str = (phase == txn);
                    rx_str = (phase == rxn);
                    phase  = ~phase;
                end
            end else begin
                gcnt++;
            end
            if (tx_str) begin
                if (last_clk === 1'b0) obs_tx_used++;
                if (tx_given < exp_n) begin tx_given++; prev_tx = 1; end
            end
            if (rx_str && rx_given < exp_n) begin
                b = (mode == 1) ? mosi : miso_drv;
                rx_bits.push_back(b);
                rx_given++;
                if (rx_given == exp_n) prev_final = 1;
            end
            @(negedge clk);
            cyc++;
        end
        pos_edge = 1'b0; neg_edge = 1'b0; start = 1'b0;
        exp_rx = '0;
        for (int k = 0; k < rx_bits.size(); k++) begin
            if (lsb_i) exp_rx[k] = rx_bits[k];
            else       exp_rx[exp_n-1-k] = rx_bits[k];
        end
        if (abort_after == 0) begin
            if (obs_mosi.size() != exp_n) obs_mosi_err++;
            for (int k = 0; k < exp_n; k++) begin
                eb = lsb_i ? d[k] : d[exp_n-1-k];
                if (k >= obs_mosi.size() || obs_mosi[k] !== eb) obs_mosi_err++;
            end
        end
        $display("xfer len=%0d lsb=%0d txneg=%0d rxneg=%0d div=%0d mode=%0d tx=%h rx=%h exp_rx=%h",
                 l, lsb_i, txn, rxn, div, mode, d, obs_rx, exp_rx);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; len = 6'd8; tx_data = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (tip !== 1'b0) $display("FAIL reset_tip got %b exp 0", tip); else n_pass++;
            n_checks++; if (go !== 1'b0) $display("FAIL reset_go got %b exp 0", go); else n_pass++;
            n_checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got %b exp 0", mosi); else n_pass++;
            n_checks++; if (rx_data !== '0) $display("FAIL reset_rx got %h exp 0", rx_data); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb8();
        logic [7:0] got;
        run_xfer(6'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 2, 1, 0, 0, 0);
        got = '0;
        for (int k = 0; k < 8 && k < obs_mosi.size(); k++) got[7-k] = obs_mosi[k];
        n_checks++; if (obs_timeout !== 0) $display("FAIL msb8_timeout got %0d exp 0", obs_timeout); else n_pass++;
        n_checks++; if (obs_proto_err !== 0) $display("FAIL msb8_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (got !== 8'b1010_0101) $display("FAIL msb8_mosi_seq got %b exp 10100101", got); else n_pass++;
        n_checks++; if (obs_tx_used !== 8) $display("FAIL msb8_tx_edges got %0d exp 8", obs_tx_used); else n_pass++;
        n_checks++; if (obs_rx !== 32'h0000_00A5) $display("FAIL msb8_rx got %h exp 000000a5", obs_rx); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL msb8_done_once got %b exp 0", done); else n_pass++;
        n_checks++; if (rx_data !== 32'h0000_00A5) $display("FAIL msb8_rx_hold got %h exp 000000a5", rx_data); else n_pass++;
    endtask

    task automatic test_lsb32();
        logic first_bit, last_bit;
        run_xfer(6'd0, 1'b1, 1'b1, 1'b0, 32'h8000_0001, 1, 1, 0, 0, 0);
        first_bit = (obs_mosi.size() > 0)  ? obs_mosi[0]  : 1'bx;
        last_bit  = (obs_mosi.size() > 31) ? obs_mosi[31] : 1'bx;
        n_checks++; if (obs_proto_err !== 0) $display("FAIL lsb32_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (first_bit !== 1'b1) $display("FAIL lsb32_first_bit got %b exp 1", first_bit); else n_pass++;
        n_checks++; if (last_bit !== 1'b1) $display("FAIL lsb32_last_bit got %b exp 1", last_bit); else n_pass++;
        n_checks++; if (obs_mosi_err !== 0) $display("FAIL lsb32_mosi errors %0d exp 0", obs_mosi_err); else n_pass++;
        n_checks++; if (obs_tx_used !== 32) $display("FAIL lsb32_tx_edges got %0d exp 32", obs_tx_used); else n_pass++;
        n_checks++; if (obs_rx !== 32'h8000_0001) $display("FAIL lsb32_rx got %h exp 80000001", obs_rx); else n_pass++;
    endtask

    task automatic test_div0();
        logic [3:0] got;
        run_xfer(6'd4, 1'b0, 1'b1, 1'b0, 32'h9, 0, 2, 0, 0, 0);
        got = '0;
        for (int k = 0; k < 4 && k < obs_mosi.size(); k++) got[3-k] = obs_mosi[k];
        n_checks++; if (obs_proto_err !== 0) $display("FAIL div0_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (got !== 4'b1001) $display("FAIL div0_mosi_seq got %b exp 1001", got); else n_pass++;
        n_checks++; if (obs_tx_used !== 4) $display("FAIL div0_tx_edges got %0d exp 4", obs_tx_used); else n_pass++;
        n_checks++; if (obs_rx !== 32'hF) $display("FAIL div0_rx got %h exp 0000000f", obs_rx); else n_pass++;
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] d;
        run_xfer(6'd16, 1'b0, 1'b1, 1'b0, $urandom, 1, 1, 5, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (tip !== 1'b0) $display("FAIL abort_tip got %b exp 0", tip); else n_pass++;
        n_checks++; if (mosi !== 1'b0) $display("FAIL abort_mosi got %b exp 0", mosi); else n_pass++;
        n_checks++; if (rx_data !== '0) $display("FAIL abort_rx got %h exp 0", rx_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", done); else n_pass++;
        d = $urandom;
        run_xfer(6'd16, 1'b0, 1'b1, 1'b0, d, 1, 1, 0, 0, 0);
        n_checks++; if (obs_proto_err !== 0) $display("FAIL abort_restart_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (obs_mosi_err !== 0) $display("FAIL abort_restart_mosi errors %0d exp 0", obs_mosi_err); else n_pass++;
        n_checks++; if (obs_rx !== (d & 32'h0000_FFFF)) $display("FAIL abort_restart_rx got %h exp %h", obs_rx, d & 32'h0000_FFFF); else n_pass++;
    endtask

    task automatic test_start_during_run();
        logic [DATA_W-1:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        run_xfer(6'd8, 1'b0, 1'b1, 1'b0, d1, 1, 1, 0, 1, 0);
        n_checks++; if (obs_proto_err !== 0) $display("FAIL ignore_start_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (obs_rx !== {24'h0, d1[7:0]}) $display("FAIL ignore_start_rx got %h exp %h", obs_rx, {24'h0, d1[7:0]}); else n_pass++;
        // Still in the done cycle: this start must be accepted.
        len = 6'd12; lsb = 1'b1; tx_negedge = 1'b0; rx_negedge = 1'b1; tx_data = d2; start = 1'b1;
        run_xfer(6'd12, 1'b1, 1'b0, 1'b1, d2, 1, 0, 0, 0, 1);
        n_checks++; if (obs_proto_err !== 0) $display("FAIL chain_start_protocol errors %0d exp 0", obs_proto_err); else n_pass++;
        n_checks++; if (obs_mosi_err !== 0) $display("FAIL chain_start_mosi errors %0d exp 0", obs_mosi_err); else n_pass++;
        n_checks++; if (obs_rx !== exp_rx) $display("FAIL chain_start_rx got %h exp %h", obs_rx, exp_rx); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_xfer(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), 0, 0, 0, 0);
            n_checks++; if (obs_timeout !== 0) $display("FAIL rand%0d_timeout got %0d exp 0", i, obs_timeout); else n_pass++;
            n_checks++; if (obs_proto_err !== 0) $display("FAIL rand%0d_protocol errors %0d exp 0", i, obs_proto_err); else n_pass++;
            n_checks++; if (obs_mosi_err !== 0) $display("FAIL rand%0d_mosi errors %0d exp 0", i, obs_mosi_err); else n_pass++;
            n_checks++; if (obs_tx_used !== exp_n) $display("FAIL rand%0d_tx_edges got %0d exp %0d", i, obs_tx_used, exp_n); else n_pass++;
            n_checks++; if (obs_rx !== exp_rx) $display("FAIL rand%0d_rx got %h exp %h", i, obs_rx, exp_rx); else n_pass++;
            @(negedge clk);
        end
    endtask

`ifdef SPI_SHIFT_CTRL_IRQ_EN
    task automatic test_irq();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq); else n_pass++;
        run_xfer(6'd6, 1'b0, 1'b1, 1'b0, $urandom, 1, 1, 0, 0, 0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_set_priority got %b exp 1", irq); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_hold got %b exp 1", irq); else n_pass++;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_ack got %b exp 0", irq); else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; lsb = 1'b0; tx_negedge = 1'b0; rx_negedge = 1'b0;
        tx_data = '0; pos_edge = 1'b0; neg_edge = 1'b0; miso_drv = 1'b0; loop_en = 1'b0;
`ifdef SPI_SHIFT_CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
        test_reset();
        test_msb8();
        test_lsb32();
        test_div0();
        test_abort();
        test_start_during_run();
        test_random();
`ifdef SPI_SHIFT_CTRL_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_shift_ctrl.md
Name: spi_shift_ctrl

Overview:
- Transfer engine directly downstream of the SPI clock generator; consumes its `pos_edge`/`neg_edge` strobes.
- Serialises a parallel word onto MOSI and deserialises MISO into a parallel word.
- Drives the generator's `go` and `last_clk` inputs, and provides `tip` for use as the generator's `enable`.
- Sits between the SPI register interface and the generator.

Parameters:
- DATA_W, 32: maximum transfer length in bits; width of `tx_data`/`rx_data`.
- CNT_W, 6: bit-counter width; must hold DATA_W (ceil(log2(DATA_W+1))).

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  synchronous reset, active-low, sampled on rising `clk_in`
- start  input  1  one-cycle request to begin a transfer; ignored while `tip`=1
- len  input  CNT_W  bits to transfer, latched at accepted start; 0 means DATA_W; values >DATA_W are clamped to DATA_W
- lsb  input  1  1 = LSB first, 0 = MSB first; latched at start
- tx_negedge  input  1  1 = MOSI changes on `neg_edge`, 0 = on `pos_edge`; latched at start
- rx_negedge  input  1  1 = MISO sampled on `neg_edge`, 0 = on `pos_edge`; latched at start
- tx_data  input  DATA_W  word to send; latched at start
- pos_edge  input  1  strobe from clock generator
- neg_edge  input  1  strobe from clock generator
- miso  input  1  serial data in
- go  output  1  one-cycle pulse to clock generator, cycle after accepted start
- tip  output  1  transfer in progress; feeds the generator's enable
- last_clk  output  1  final bit launched; feeds the generator's `last_clk`
- mosi  output  1  serial data out
- rx_data  output  DATA_W  received word
- done  output  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; tip, go, last_clk, mosi, done = 0; rx_data = 0; counters = 0.
- Reset mid-transfer aborts it immediately; no done pulse.
- States: IDLE, RUN.
- IDLE -> RUN on start=1:
  - latch all config and tx_data into a shadow shift register.
  - tx_cnt = rx_cnt = N, where N = effective length.
  - clear rx_data.
  - tip=1 and go=1 from the next cycle; go lasts exactly one cycle.
- tx_edge = tx_negedge ? neg_edge : pos_edge; rx_edge = rx_negedge ? neg_edge : pos_edge (latched selects).
- In RUN, on tx_edge with tx_cnt != 0:
  - mosi <= next bit, tx_cnt decrements.
  - Bit order: MSB first sends tx_data[N-1] down to [0]; LSB first sends [0] up to [N-1].
- tx_edge with tx_cnt = 0: mosi holds.
- In RUN, on rx_edge with rx_cnt != 0:
  - MSB first: rx_data <= {rx_data[DATA_W-2:0], miso}; the final value sits in rx_data[N-1:0], upper bits 0.
  - LSB first: rx_data[N-rx_cnt] <= miso.
  - rx_cnt decrements.
- last_clk = tip && (tx_cnt == 0), registered so it is valid the cycle after the final tx_edge.
- Completion: the rx_edge that takes rx_cnt 1->0 ends the transfer.
  - Next cycle: tip=0, done=1 for one cycle, state IDLE; rx_data is stable and holds until the next accepted start.
- Simultaneous tx_edge and rx_edge (same selected edge): both actions occur in the same cycle.
- pos_edge and neg_edge both high in one cycle (divider 0 case): each selected action occurs once.
- start while tip=1: ignored, no state change.
- start in the same cycle done is asserted: accepted (state is already IDLE).
- Edges in IDLE: ignored; mosi holds its last value.

Optional Feature:
- Macro: SPI_SHIFT_CTRL_IRQ_EN.
- Defined: adds ports irq (output, 1) and irq_ack (input, 1).
  - irq is set on done, cleared on irq_ack or reset.
  - Set has priority if done and irq_ack coincide.
- Undefined: ports absent; no additional logic.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start=1 -> tip=0, go=0, mosi=0, rx_data=0, no done.
- MSB first, len=8, tx_data=0xA5, tx_negedge=1, rx_negedge=0, miso looped to mosi, clock generator with divider=2 -> mosi sequence 1,0,1,0,0,1,0,1; go one cycle after start; last_clk after the 8th neg_edge; done once; rx_data=0x000000A5.
- LSB first, len=0 (32 bits), tx_data=0x8000_0001, loopback -> first mosi bit 1, 32nd bit 1, rx_data=0x8000_0001, exactly 32 tx edges consumed.
- Divider 0 (pos_edge and neg_edge in the same cycle), len=4, tx_data=0x9, miso tied 1 -> mosi 1,0,0,1; rx_data=0xF; done after 4th rx edge.
- Abort: start len=16, pull rst_n low after 5 bits -> tip=0 the next cycle, no done, a new start afterwards behaves normally.
- start pulsed during RUN and in the same cycle as done -> first ignored, second accepted (go pulses); with SPI_SHIFT_CTRL_IRQ_EN, irq=1 after done until irq_ack.
